// File: rtl/imem_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory port arbiter: FSM encoding and default sizes.
package imem_access_ctrl_pkg;

    localparam int IMEM_ADDR_W     = 16;
    localparam int IMEM_DATA_W     = 32;
    localparam int IMEM_DEPTH      = 256;
    localparam int IMEM_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_starve_timer.sv
// Purpose: counts cycles a pending load has waited behind fetch; flags the limit cycle.
// Latency: hit is combinational from the current count; count updates on the next edge.
// Backpressure: none; clr has priority over inc.
module imem_starve_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/imem_access_ctrl.sv
// Purpose: shares the single instruction-memory port between CPU fetch and a burst program loader.
// Latency: fetch data 1 cycle after an accepted f_req; ld_done 1 cycle after the last write or a reject.
// Backpressure: f_stall while the loader owns the port; ld_wready only in LOAD; a waiting load is starved at most STARVE_MAX cycles.
module imem_access_ctrl
    import imem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int DEPTH      = IMEM_DEPTH,
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_data,
    output logic              f_stall,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_wvalid,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_wready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    imem_state_t       state, nxt;
    logic [ADDR_W-1:0] ptr, rem;
    logic              serve, accept, reject, wr;
    logic              t_inc, t_clr, t_hit;
    logic [ADDR_W:0]   end_x;
    logic              range_bad;

    // One extra bit so base+len cannot wrap and slip past the bound.
    assign end_x     = {1'b0, ld_base} + {1'b0, ld_len};
    assign range_bad = (ld_len == '0) || (end_x > DEPTH_X);

    imem_starve_timer #(
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (t_inc),
        .clr   (t_clr),
        .hit   (t_hit)
    );

    always_comb begin
        nxt        = state;
        serve      = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        wr         = 1'b0;
        t_inc      = 1'b0;
        t_clr      = 1'b1;
        f_stall    = 1'b0;
        ld_wready  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_datain = '0;
        case (state)
            ST_IDLE: begin
                serve = f_req;
                if (ld_start) begin
                    if (range_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept = 1'b1;
                        nxt    = f_req ? ST_PEND : ST_LOAD;
                    end
                end
            end
            ST_PEND: begin
                serve = f_req;
                t_clr = 1'b0;
                t_inc = f_req;
                if (!f_req || t_hit) begin
                    nxt   = ST_LOAD;
                    t_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                f_stall   = 1'b1;
                ld_wready = 1'b1;
                mem_addr  = ptr;
                if (ld_wvalid) begin
                    wr         = 1'b1;
                    mem_write  = 1'b1;
                    mem_datain = ld_wdata;
                    if (rem == ADDR_W'(1)) begin
                        nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                nxt = ST_IDLE;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
        if (serve) begin
            mem_addr = f_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_valid <= 1'b0;
            f_data  <= '0;
        end else begin
            f_valid <= serve;
            if (serve) begin
                f_data <= mem_dataout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            rem     <= '0;
            ld_busy <= 1'b0;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            ld_busy <= (nxt == ST_PEND) || (nxt == ST_LOAD);
            ld_done <= reject || (wr && (rem == ADDR_W'(1)));
            if (reject) begin
                ld_err <= 1'b1;
            end else if (accept) begin
                ld_err <= 1'b0;
            end
            if (accept) begin
                ptr <= ld_base;
                rem <= ld_len;
            end else if (wr) begin
                ptr <= ptr + ADDR_W'(1);
                rem <= rem - ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a 256x32 memory model preloaded with 0xC0DE0000+addr.
module tb_imem_access_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [31:0] PAT = 32'hC0DE_0000;

    logic              clk;
    logic              reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_valid;
    logic [DATA_W-1:0] f_data;
    logic              f_stall;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W-1:0] ld_len;
    logic              ld_wvalid;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_wready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;

    logic [DATA_W-1:0] mem [0:255];
    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;

    imem_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_valid     (f_valid),
        .f_data      (f_data),
        .f_stall     (f_stall),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_wvalid   (ld_wvalid),
        .ld_wdata    (ld_wdata),
        .ld_wready   (ld_wready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = PAT + 32'(i);
    end

    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            mem[mem_addr[7:0]] <= mem_datain;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign mem_dataout = (mem_addr < 16'd256) ? mem[mem_addr[7:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous-write burst with fetch idle; ends one cycle after the DONE pulse.
    task automatic burst(input logic [15:0] base, input logic [15:0] len, input logic [31:0] dbase);
        ld_base  = base;
        ld_len   = len;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("burst_err_clr", ld_err, 0);
        for (int k = 0; k < int'(len); k++) begin
            ld_wvalid = 1'b1;
            ld_wdata  = dbase + 32'(k);
            tick();
        end
        ld_wvalid = 1'b0;
        chk("burst_done", ld_done, 1);
        tick();
    endtask

    initial begin
        int w0;
        int written;
        logic [4:0] gap_pat;
        reset = 1'b0; f_req = 1'b0; f_addr = '0; ld_start = 1'b0;
        ld_base = '0; ld_len = '0; ld_wvalid = 1'b0; ld_wdata = '0;
        #12;
        chk("rst_f_valid", f_valid, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_ld_busy", ld_busy, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_ld_err", ld_err, 0);
        chk("rst_f_stall", f_stall, 0);
        chk("rst_mem_write", mem_write, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Back-to-back fetches.
        f_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_addr = 16'(i);
            #1 chk("f1_addr", mem_addr, i);
            tick();
            chk("f1_valid", f_valid, 1);
            chk("f1_data", f_data, PAT + 32'(i));
        end
        f_req = 1'b0;
        tick();
        chk("f1_valid_off", f_valid, 0);

        // Plain burst with fetch idle.
        ld_base = 16; ld_len = 4; ld_start = 1'b1;
        #1 chk("t2_stall_start", f_stall, 0);
        tick();
        ld_start = 1'b0;
        chk("t2_busy", ld_busy, 1);
        for (int k = 0; k < 4; k++) begin
            ld_wvalid = 1'b1;
            ld_wdata  = 32'hA0 + 32'(k);
            #1;
            chk("t2_stall", f_stall, 1);
            chk("t2_wready", ld_wready, 1);
            chk("t2_we", mem_write, 1);
            chk("t2_addr", mem_addr, 16 + k);
            chk("t2_done_early", ld_done, 0);
            tick();
        end
        ld_wvalid = 1'b0;
        chk("t2_done", ld_done, 1);
        chk("t2_busy_off", ld_busy, 0);
        chk("t2_stall_done", f_stall, 0);
        tick();
        chk("t2_done_pulse", ld_done, 0);
        for (int k = 0; k < 4; k++) chk("t2_mem", mem[16 + k], 32'hA0 + 32'(k));

        // Starvation: fetch keeps requesting while a load waits.
        f_req = 1'b1; f_addr = 5;
        ld_base = 0; ld_len = 2; ld_start = 1'b1;
        #1 chk("t3_start_fetch", mem_addr, 5);
        tick();
        ld_start = 1'b0;
        chk("t3_busy", ld_busy, 1);
        chk("t3_fv0", f_valid, 1);
        chk("t3_fd0", f_data, PAT + 32'd5);
        for (int p = 0; p < 8; p++) begin
            f_addr = 16'(32 + p);
            #1;
            chk("t3_pend_stall", f_stall, 0);
            chk("t3_pend_addr", mem_addr, 32 + p);
            tick();
            chk("t3_pend_fv", f_valid, 1);
            chk("t3_pend_fd", f_data, PAT + 32'(32 + p));
        end
        chk("t3_load_stall", f_stall, 1);
        chk("t3_load_wready", ld_wready, 1);
        chk("t3_load_addr", mem_addr, 0);
        tick();
        chk("t3_load_fv", f_valid, 0);
        chk("t3_load_stall2", f_stall, 1);
        for (int k = 0; k < 2; k++) begin
            ld_wvalid = 1'b1;
            ld_wdata  = 32'hB0 + 32'(k);
            tick();
        end
        ld_wvalid = 1'b0;
        chk("t3_done", ld_done, 1);
        tick();
        chk("t3_done_no_fetch", f_valid, 0);
        f_req = 1'b0;
        tick();
        chk("t3_mem0", mem[0], 32'hB0);
        chk("t3_mem1", mem[1], 32'hB1);

        // Rejected starts, then legal starts (including one ending exactly at the top).
        w0 = wr_cnt;
        ld_base = 0; ld_len = 0; ld_start = 1'b1;
        #1 chk("t4_z_we", mem_write, 0);
        tick();
        ld_start = 1'b0;
        chk("t4_z_err", ld_err, 1);
        chk("t4_z_done", ld_done, 1);
        chk("t4_z_busy", ld_busy, 0);
        tick();
        chk("t4_z_done_pulse", ld_done, 0);
        chk("t4_z_err_sticky", ld_err, 1);
        burst(16'd100, 16'd1, 32'hC5);
        chk("t4_mem100", mem[100], 32'hC5);
        w0 = wr_cnt;
        ld_base = 250; ld_len = 10; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("t4_r_err", ld_err, 1);
        chk("t4_r_done", ld_done, 1);
        chk("t4_r_stall", f_stall, 0);
        tick();
        chk("t4_no_write", wr_cnt, w0);
        burst(16'd252, 16'd4, 32'hE8);
        chk("t4_mem255", mem[255], 32'hEB);

        // Gapped writes.
        w0 = wr_cnt;
        gap_pat = 5'b11001;
        written = 0;
        ld_base = 40; ld_len = 3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ld_wvalid = gap_pat[c];
            ld_wdata  = gap_pat[c] ? (32'hD0 + 32'(written)) : 32'hDEAD_BEEF;
            #1;
            chk("t5_we", mem_write, gap_pat[c]);
            chk("t5_addr", mem_addr, 40 + written);
            if (gap_pat[c]) written++;
            tick();
        end
        ld_wvalid = 1'b0;
        chk("t5_done", ld_done, 1);
        tick();
        chk("t5_count", wr_cnt - w0, 3);
        for (int k = 0; k < 3; k++) chk("t5_mem", mem[40 + k], 32'hD0 + 32'(k));
        chk("t5_mem_after", mem[43], PAT + 32'd43);

        // Reset in the middle of a burst.
        ld_base = 60; ld_len = 5; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_wvalid = 1'b1;
            ld_wdata  = 32'hE0 + 32'(k);
            tick();
        end
        ld_wvalid = 1'b0;
        chk("t6_busy_pre", ld_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", ld_busy, 0);
        chk("t6_stall", f_stall, 0);
        chk("t6_wready", ld_wready, 0);
        chk("t6_we", mem_write, 0);
        chk("t6_done", ld_done, 0);
        chk("t6_err", ld_err, 0);
        chk("t6_f_data", f_data, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t6_no_done", ld_done, 0);
        f_req = 1'b1; f_addr = 61;
        tick();
        f_req = 1'b0;
        chk("t6_fv", f_valid, 1);
        chk("t6_fd", f_data, 32'hE1);
        chk("t6_mem60", mem[60], 32'hE0);
        chk("t6_mem62", mem[62], PAT + 32'd62);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
